// File: rtl/nes_pad_responder_pkg.sv
// rtl/nes_pad_responder_pkg.sv - shared types and constants for the NES pad responder
package nes_pad_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } pad_state_t;

  localparam int PAD_BITS = 8;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_pad_responder_sync_edge.sv
// rtl/nes_pad_responder_sync_edge.sv - pin synchronizer with rise/fall detection
module pad_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   history;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain   <= '0;
      history <= 1'b0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], pin};
      history <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~history;
  assign fall  = ~level & history;

endmodule

// File: rtl/nes_pad_responder.sv
// rtl/nes_pad_responder.sv - responder end of the NES latch/clock/data pad protocol
module nes_pad_responder
  import nes_pad_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096,
  parameter int TW          = 13
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       pad_latch,
  input  logic       pad_clock,
  input  logic [7:0] buttons,
  output logic       pad_data,
  output logic       frame_done,
  output logic       frame_timeout,
  output logic [3:0] bit_count
);

  localparam logic [3:0]    LAST_BIT  = 4'(PAD_BITS - 1);
  localparam logic [3:0]    FULL_CNT  = 4'(PAD_BITS);
  localparam logic [TW-1:0] TIMEOUT_M = TW'(TIMEOUT - 1);

  logic latch_level, latch_rise, latch_fall;
  logic clock_level, clock_rise, clock_fall;

  pad_state_t          state, state_next;
  logic [PAD_BITS-1:0] shreg, shreg_next;
  logic [3:0]          count_next;
  logic [TW-1:0]       tcount, tcount_next;
  logic                pad_next, done_next, timeout_next;

  logic unused_levels;
  assign unused_levels = &{1'b0, latch_level, clock_level, clock_fall};

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (PCLK),
    .rst   (PRESET),
    .pin   (pad_latch),
    .level (latch_level),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clock_sync (
    .clk   (PCLK),
    .rst   (PRESET),
    .pin   (pad_clock),
    .level (clock_level),
    .rise  (clock_rise),
    .fall  (clock_fall)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_count     <= '0;
      tcount        <= '0;
      pad_data      <= 1'b1;
      frame_done    <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      state         <= state_next;
      shreg         <= shreg_next;
      bit_count     <= count_next;
      tcount        <= tcount_next;
      pad_data      <= pad_next;
      frame_done    <= done_next;
      frame_timeout <= timeout_next;
    end
  end

  // A latch rise preempts everything, including a clock edge in the same cycle.
  always_comb begin
    state_next = state;
    if (latch_rise) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:  state_next = IDLE;
        LOAD:  if (latch_fall) state_next = SHIFT;
        SHIFT: begin
          if (clock_rise) begin
            if (bit_count == LAST_BIT) state_next = DONE;
          end else if (tcount == TIMEOUT_M) begin
            state_next = IDLE;
          end
        end
        DONE:  state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    shreg_next   = shreg;
    count_next   = bit_count;
    tcount_next  = tcount;
    pad_next     = pad_data;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    if (latch_rise) begin
      shreg_next  = buttons;
      pad_next    = ~buttons[BTN_A];
      count_next  = '0;
      tcount_next = '0;
    end else begin
      case (state)
        IDLE: begin
          pad_next    = 1'b1;
          count_next  = '0;
          tcount_next = '0;
        end
        // Track live buttons until the latch falls; the last load is the snapshot.
        LOAD: begin
          shreg_next  = buttons;
          pad_next    = ~buttons[BTN_A];
          count_next  = '0;
          tcount_next = '0;
        end
        SHIFT: begin
          if (clock_rise) begin
            shreg_next  = {shreg[PAD_BITS-2:0], 1'b0};
            count_next  = bit_count + 4'd1;
            tcount_next = '0;
            if (bit_count == LAST_BIT) begin
              pad_next  = 1'b0;
              done_next = 1'b1;
            end else begin
              pad_next  = ~shreg[PAD_BITS-2];
            end
          end else if (tcount == TIMEOUT_M) begin
            timeout_next = 1'b1;
            count_next   = '0;
            pad_next     = 1'b1;
            tcount_next  = '0;
          end else begin
            tcount_next  = tcount + TW'(1);
          end
        end
        // Real pads read as pressed past the 8th bit, so the line stays low.
        DONE: begin
          pad_next   = 1'b0;
          count_next = FULL_CNT;
        end
        default: begin
          pad_next = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb/tb_nes_pad_responder.sv - self-checking bench for nes_pad_responder
module tb_nes_pad_responder;

  localparam int TIMEOUT_CYC = 4096;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       pad_latch = 1'b0;
  logic       pad_clock = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       pad_data;
  logic       frame_done;
  logic       frame_timeout;
  logic [3:0] bit_count;

  nes_pad_responder dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .pad_latch     (pad_latch),
    .pad_clock     (pad_clock),
    .buttons       (buttons),
    .pad_data      (pad_data),
    .frame_done    (frame_done),
    .frame_timeout (frame_timeout),
    .bit_count     (bit_count)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  int to_cnt   = 0;

  always @(posedge PCLK) begin
    #1;
    if (frame_done === 1'b1) done_cnt++;
    if (frame_timeout === 1'b1) to_cnt++;
  end

  typedef struct {
    bit         latch;
    bit         clk;
    logic [7:0] btn;
    int         hold;
    bit         exp_pad;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic drive(input bit l, input bit c, input logic [7:0] b);
    pad_latch = l;
    pad_clock = c;
    buttons   = b;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    drive(1'b0, 1'b0, buttons);
    step(3);
    PRESET = 1'b0;
    step(5);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit   a5_pad [8];
    bit   f01_pad[8];
    int   d0, t0, hit, exp_done;
    int   phase, n;
    bit   lat, clk;
    logic [7:0] snap;

    a5_pad  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    f01_pad = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    tbl.push_back('{1'b0, 1'b0, 8'h00, 20, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b0, 8'hA5, 10, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 8'hA5, 20, 1'b0, 0});
    for (int k = 0; k < 8; k++) begin
      tbl.push_back('{1'b0, 1'b1, 8'hA5, 20, a5_pad[k], k + 1});
      tbl.push_back('{1'b0, 1'b0, 8'hA5, 20, a5_pad[k], k + 1});
    end
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{1'b0, 1'b1, 8'hA5, 20, 1'b0, 8});
      tbl.push_back('{1'b0, 1'b0, 8'hA5, 20, 1'b0, 8});
    end

    // reset state
    step(2);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    check("reset_pad", pad_data, 1);
    check("reset_cnt", bit_count, 0);
    check("reset_done", frame_done, 0);
    check("reset_timeout", frame_timeout, 0);
    @(negedge PCLK);

    // table: idle, A5 frame, extra clocks
    d0 = done_cnt;
    t0 = to_cnt;
    foreach (tbl[i]) begin
      drive(tbl[i].latch, tbl[i].clk, tbl[i].btn);
      step(tbl[i].hold);
      check($sformatf("vec%0d_pad", i), pad_data, tbl[i].exp_pad);
      check($sformatf("vec%0d_cnt", i), bit_count, tbl[i].exp_cnt);
      if (i == 0) check("idle_no_pulse", done_cnt + to_cnt - d0 - t0, 0);
    end
    check("a5_done_once", done_cnt - d0, 1);
    check("a5_no_timeout", to_cnt - t0, 0);

    // aborted frame followed by a fresh frame
    d0 = done_cnt;
    drive(1'b0, 1'b0, 8'hFF); step(5);
    drive(1'b1, 1'b0, 8'hFF); step(10);
    drive(1'b0, 1'b0, 8'hFF); step(20);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 8'hFF); step(20);
      drive(1'b0, 1'b0, 8'hFF); step(20);
    end
    check("abort_mid_cnt", bit_count, 3);
    drive(1'b1, 1'b0, 8'h01); step(10);
    check("abort_relatch_cnt", bit_count, 0);
    check("abort_no_done", done_cnt - d0, 0);
    drive(1'b0, 1'b0, 8'h01); step(20);
    check("f01_fall_pad", pad_data, 1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 8'($urandom)); step(20);
      check($sformatf("f01_rise%0d_pad", k + 1), pad_data, f01_pad[k]);
      drive(1'b0, 1'b0, 8'($urandom)); step(20);
    end
    check("f01_done_once", done_cnt - d0, 1);

    // timeout after two clocks
    t0 = to_cnt;
    drive(1'b1, 1'b0, 8'hA5); step(10);
    drive(1'b0, 1'b0, 8'hA5); step(20);
    drive(1'b0, 1'b1, 8'hA5); step(20);
    drive(1'b0, 1'b0, 8'hA5); step(20);
    drive(1'b0, 1'b1, 8'hA5);
    hit = -1;
    for (int k = 1; k <= TIMEOUT_CYC + 8; k++) begin
      @(posedge PCLK); #1;
      if (k == 20) pad_clock = 1'b0;
      if (k == 10) check("timeout_pre_cnt", bit_count, 2);
      if (frame_timeout === 1'b1 && hit < 0) hit = k;
    end
    check("timeout_latency", hit, TIMEOUT_CYC + 3);
    check("timeout_once", to_cnt - t0, 1);
    check("timeout_pad", pad_data, 1);
    check("timeout_cnt", bit_count, 0);
    @(negedge PCLK);
    drive(1'b0, 1'b1, 8'hA5); step(10);
    drive(1'b0, 1'b0, 8'hA5); step(10);
    check("timeout_idle_cnt", bit_count, 0);
    check("timeout_idle_pad", pad_data, 1);

    // edge-to-output latency
    drive(1'b0, 1'b0, 8'hC0); step(5);
    pad_latch = 1'b1;
    @(posedge PCLK); @(posedge PCLK); #1;
    check("latency_before3", pad_data, 1);
    @(posedge PCLK); #1;
    check("latency_at3", pad_data, 0);
    @(negedge PCLK);

    // simultaneous latch and clock edges, then reset mid-shift
    d0 = done_cnt;
    t0 = to_cnt;
    drive(1'b0, 1'b0, 8'hC0); step(20);
    drive(1'b0, 1'b1, 8'hC0); step(20);
    drive(1'b0, 1'b0, 8'hC0); step(20);
    drive(1'b0, 1'b1, 8'hC0); step(20);
    drive(1'b0, 1'b0, 8'hC0); step(20);
    check("simul_pre_cnt", bit_count, 2);
    drive(1'b1, 1'b1, 8'hC0); step(10);
    check("simul_rise_cnt", bit_count, 0);
    check("simul_rise_pad", pad_data, 0);
    drive(1'b1, 1'b0, 8'hC0); step(10);
    drive(1'b0, 1'b1, 8'hC0); step(10);
    check("fall_rise_cnt", bit_count, 0);
    check("fall_rise_pad", pad_data, 0);
    drive(1'b0, 1'b0, 8'hC0); step(10);
    drive(1'b0, 1'b1, 8'hC0); step(10);
    check("shift_one_cnt", bit_count, 1);
    check("shift_one_pad", pad_data, 0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("midreset_pad", pad_data, 1);
    check("midreset_cnt", bit_count, 0);
    check("midreset_done", frame_done, 0);
    check("midreset_timeout", frame_timeout, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    step(10);
    drive(1'b0, 1'b0, 8'hC0); step(10);
    drive(1'b0, 1'b1, 8'hC0); step(10);
    check("postreset_idle_cnt", bit_count, 0);
    check("postreset_idle_pad", pad_data, 1);
    check("simul_no_pulses", done_cnt + to_cnt - d0 - t0, 0);

    // randomized traffic against a pad-level model
    do_reset();
    d0 = done_cnt;
    t0 = to_cnt;
    exp_done = 0;
    phase = 0;
    n = 0;
    lat = 1'b0;
    clk = 1'b0;
    snap = 8'h00;
    for (int it = 0; it < 300; it++) begin
      int op;
      bit exp_pad;
      int exp_cnt;
      op = int'($urandom_range(0, 9));
      if (op < 2) begin
        if (!lat) begin
          buttons = 8'($urandom);
          lat = 1'b1;
          phase = 1;
        end else begin
          lat = 1'b0;
          if (phase == 1) begin
            phase = 2;
            snap = buttons;
            n = 0;
          end
        end
      end else if (op == 2) begin
        buttons = 8'($urandom);
      end else begin
        if (!clk) begin
          clk = 1'b1;
          if (phase == 2 && n < 8) begin
            n++;
            if (n == 8) exp_done++;
          end
        end else begin
          clk = 1'b0;
        end
      end
      pad_latch = lat;
      pad_clock = clk;
      step(int'($urandom_range(4, 8)));
      if (phase == 0) begin
        exp_pad = 1'b1;
        exp_cnt = 0;
      end else if (phase == 1) begin
        exp_pad = ~buttons[7];
        exp_cnt = 0;
      end else begin
        exp_pad = (n < 8) ? ~snap[7 - n] : 1'b0;
        exp_cnt = n;
      end
      check($sformatf("rand%0d_pad", it), pad_data, exp_pad);
      check($sformatf("rand%0d_cnt", it), bit_count, exp_cnt);
    end
    check("rand_done_count", done_cnt - d0, exp_done);
    check("rand_no_timeout", to_cnt - t0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
